dmem_port_arbiter: RTL and testbench

Shares the single data-memory port between the pipeline's memory stage (core port) and a secondary bus master such as a DMA or debug unit (aux port). It sits between the memory stage and the data memory and sequences each access as a multi-cycle transaction that completes on a memory ready handshake. It stalls the pipeline while the core's access is pending and aborts any transaction the memory fails to acknowledge within a timeout.

---
 rtl/dmem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//
// Shares the single data-memory port between the pipeline memory stage (core)
// and a secondary bus master (aux, e.g. DMA or debug). Each access is a
// multi-cycle transaction: a winner is picked in IDLE, its request is latched,
// and the memory request is held in BUSY_CORE / BUSY_AUX until dready_i or a
// timeout returns the FSM to IDLE.
//
// Handshakes:
//   core: core_rd_i/core_wr_i is a level request held while core_stall_o=1;
//         the access completes in the cycle core_stall_o falls.
//   aux:  aux_req_i is sampled in IDLE; aux_gnt_o pulses when it is captured,
//         aux_rvalid_o pulses one cycle after the memory access ends.
//   mem:  drd_o/dwr_o stay asserted with stable address/data until dready_i=1.
//
// Ports:
//   clk_i, reset_ni            clock, async active-low reset
//   core_*                     memory-stage request and stall/result
//   aux_*                      secondary master request/grant/result
//   daddr_o .. dwr_o           data-memory request
//   drdata_i, dready_i         data-memory response
//   state_o                    FSM state (0=IDLE, 1=BUSY_CORE, 2=BUSY_AUX)
module dmem_port_arbiter #(
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        core_rd_i,
  input  logic        core_wr_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [1:0]  core_size_i,
  output logic        core_stall_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  input  logic        aux_req_i,
  input  logic        aux_we_i,
  input  logic [31:0] aux_addr_i,
  input  logic [31:0] aux_wdata_i,
  input  logic [1:0]  aux_size_i,
  output logic        aux_gnt_o,
  output logic        aux_rvalid_o,
  output logic [31:0] aux_rdata_o,
  output logic        aux_err_o,
  output logic [31:0] daddr_o,
  output logic [31:0] dwdata_o,
  output logic [1:0]  dsize_o,
  output logic        drd_o,
  output logic        dwr_o,
  input  logic [31:0] drdata_i,
  input  logic        dready_i,
  output logic [1:0]  state_o
);

  localparam int WCW = $clog2(TIMEOUT);
  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT - 1);
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY_CORE = 2'd1,
    BUSY_AUX  = 2'd2
  } state_t;

  state_t          state;
  logic [WCW-1:0]  wait_cnt;
  logic [SCW-1:0]  starve_cnt;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic [1:0]      req_size;
  logic            req_we;
  logic            aux_rvalid_q;
  logic            aux_err_q;
  logic [31:0]     aux_rdata_q;

  logic core_req;
  logic busy;
  logic at_limit;
  logic finish;
  logic timed_out;
  logic core_win;
  logic aux_win;
  logic core_done;
  logic aux_done;

  assign core_req  = core_rd_i | core_wr_i;
  assign busy      = (state != IDLE);
  assign at_limit  = (wait_cnt == WAIT_LAST);
  // dready_i in the last allowed cycle still counts as a successful access.
  assign finish    = busy & (dready_i | at_limit);
  assign timed_out = busy & ~dready_i & at_limit;
  // Core has priority unless aux has already waited through STARVE_MAX core grants.
  assign core_win  = core_req & ~(aux_req_i & (starve_cnt == STARVE_LIM));
  assign aux_win   = aux_req_i & ~core_win;
  assign core_done = (state == BUSY_CORE) & finish;
  assign aux_done  = (state == BUSY_AUX) & finish;

  // Memory request is gated by the state so IDLE (and reset) drives all zeros.
  assign daddr_o  = busy ? req_addr  : '0;
  assign dwdata_o = busy ? req_wdata : '0;
  assign dsize_o  = busy ? req_size  : '0;
  assign drd_o    = busy & ~req_we;
  assign dwr_o    = busy & req_we;

  // A core request that was withdrawn mid-transaction gets no result.
  assign core_stall_o = core_req & ~core_done;
  assign core_rdata_o = (core_done & core_req & ~timed_out & ~req_we) ? drdata_i : '0;
  assign core_err_o   = core_done & core_req & timed_out;

  assign aux_gnt_o    = (state == IDLE) & aux_win;
  assign aux_rvalid_o = aux_rvalid_q;
  assign aux_err_o    = aux_err_q;
  assign aux_rdata_o  = aux_rdata_q;
  assign state_o      = state;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      starve_cnt   <= '0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_size     <= '0;
      req_we       <= 1'b0;
      aux_rvalid_q <= 1'b0;
      aux_err_q    <= 1'b0;
      aux_rdata_q  <= '0;
    end else begin
      aux_rvalid_q <= aux_done;
      aux_err_q    <= aux_done & timed_out;
      if (aux_done) begin
        aux_rdata_q <= (timed_out | req_we) ? '0 : drdata_i;
      end

      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (core_win || aux_win) begin
            req_addr  <= core_win ? core_addr_i  : aux_addr_i;
            req_wdata <= core_win ? core_wdata_i : aux_wdata_i;
            req_size  <= core_win ? core_size_i  : aux_size_i;
            req_we    <= core_win ? core_wr_i    : aux_we_i;
            state     <= core_win ? BUSY_CORE    : BUSY_AUX;
          end
          if (core_win && aux_req_i) begin
            if (starve_cnt != STARVE_LIM) begin
              starve_cnt <= starve_cnt + SCW'(1);
            end
          end else if (aux_win || !aux_req_i) begin
            starve_cnt <= '0;
          end
        end
        BUSY_CORE, BUSY_AUX: begin
          if (finish) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter (TIMEOUT=16, STARVE_MAX=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_dmem_port_arbiter;

  logic        clk_i;
  logic        reset_ni;
  logic        core_rd_i, core_wr_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic [1:0]  core_size_i;
  logic        core_stall_o;
  logic [31:0] core_rdata_o;
  logic        core_err_o;
  logic        aux_req_i, aux_we_i;
  logic [31:0] aux_addr_i, aux_wdata_i;
  logic [1:0]  aux_size_i;
  logic        aux_gnt_o, aux_rvalid_o, aux_err_o;
  logic [31:0] aux_rdata_o;
  logic [31:0] daddr_o, dwdata_o;
  logic [1:0]  dsize_o;
  logic        drd_o, dwr_o;
  logic [31:0] drdata_i;
  logic        dready_i;
  logic [1:0]  state_o;

  int checks = 0;
  int failures = 0;

  dmem_port_arbiter #(.TIMEOUT(16), .STARVE_MAX(4)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .core_rd_i(core_rd_i), .core_wr_i(core_wr_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i), .core_size_i(core_size_i),
    .core_stall_o(core_stall_o), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
    .aux_req_i(aux_req_i), .aux_we_i(aux_we_i),
    .aux_addr_i(aux_addr_i), .aux_wdata_i(aux_wdata_i), .aux_size_i(aux_size_i),
    .aux_gnt_o(aux_gnt_o), .aux_rvalid_o(aux_rvalid_o),
    .aux_rdata_o(aux_rdata_o), .aux_err_o(aux_err_o),
    .daddr_o(daddr_o), .dwdata_o(dwdata_o), .dsize_o(dsize_o),
    .drd_o(drd_o), .dwr_o(dwr_o),
    .drdata_i(drdata_i), .dready_i(dready_i),
    .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic core_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int ready_at, input logic [31:0] mem_data,
                             output logic done, output int stalls, output int busy,
                             output logic [31:0] rdata, output logic err, output logic bus_ok);
    done = 1'b0; stalls = 0; busy = 0; rdata = '0; err = 1'b0; bus_ok = 1'b1;
    core_rd_i = ~we; core_wr_i = we; core_addr_i = addr; core_wdata_i = wdata;
    core_size_i = 2'b10; drdata_i = mem_data;
    for (int c = 0; c < 40 && !done; c++) begin
      dready_i = (drd_o | dwr_o) && (ready_at == busy + 1);
      @(negedge clk_i);
      if (core_stall_o) stalls++;
      if (drd_o | dwr_o) begin
        busy++;
        if (drd_o !== ~we || dwr_o !== we || daddr_o !== addr || dsize_o !== 2'b10 ||
            (we && dwdata_o !== wdata)) bus_ok = 1'b0;
      end
      if (!core_stall_o) begin
        done = 1'b1; rdata = core_rdata_o; err = core_err_o;
      end else if (core_rdata_o !== 32'h0 || core_err_o !== 1'b0) begin
        bus_ok = 1'b0;
      end
      @(posedge clk_i); #1;
    end
    core_rd_i = 1'b0; core_wr_i = 1'b0; dready_i = 1'b0;
  endtask

  task automatic aux_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int ready_at, input logic [31:0] mem_data,
                            output logic done, output int gnt_c, output int acc_c,
                            output int rv_c, output int busy,
                            output logic [31:0] rdata, output logic err);
    done = 1'b0; gnt_c = -1; acc_c = -1; rv_c = -1; busy = 0; rdata = '0; err = 1'b0;
    aux_req_i = 1'b1; aux_we_i = we; aux_addr_i = addr; aux_wdata_i = wdata;
    aux_size_i = 2'b10; drdata_i = mem_data;
    for (int c = 0; c < 40 && !done; c++) begin
      dready_i = (drd_o | dwr_o) && (ready_at == busy + 1);
      @(negedge clk_i);
      if (aux_gnt_o && gnt_c < 0) gnt_c = c;
      if (drd_o | dwr_o) begin
        busy++;
        if (acc_c < 0) acc_c = c;
      end
      if (aux_rvalid_o) begin
        done = 1'b1; rv_c = c; rdata = aux_rdata_o; err = aux_err_o;
      end
      @(posedge clk_i); #1;
      if (gnt_c >= 0) aux_req_i = 1'b0;
    end
    aux_req_i = 1'b0; dready_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_ni = 1'b0;
    core_rd_i = 0; core_wr_i = 0; core_addr_i = 0; core_wdata_i = 0; core_size_i = 0;
    aux_req_i = 0; aux_we_i = 0; aux_addr_i = 0; aux_wdata_i = 0; aux_size_i = 0;
    drdata_i = 0; dready_i = 0;
    idle_cycles(3);
    @(negedge clk_i);
    checks++;
    if (state_o !== 2'd0) begin
      failures++; $display("FAIL reset_state: got %0d expected 0", state_o);
    end
    checks++;
    if ({drd_o, dwr_o, daddr_o, dwdata_o, dsize_o} !== '0) begin
      failures++; $display("FAIL reset_mem_outputs: got rd=%b wr=%b addr=%h expected all 0",
                           drd_o, dwr_o, daddr_o);
    end
    checks++;
    if ({core_stall_o, core_err_o, core_rdata_o, aux_gnt_o, aux_rvalid_o, aux_err_o, aux_rdata_o} !== '0) begin
      failures++; $display("FAIL reset_port_outputs: got stall=%b gnt=%b rvalid=%b rdata=%h expected all 0",
                           core_stall_o, aux_gnt_o, aux_rvalid_o, aux_rdata_o);
    end
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_core_load();
    logic done, err, ok; int stalls, busy; logic [31:0] rdata;
    core_access(1'b0, 32'h0000_0040, 32'h0, 1, 32'hDEAD_BEEF, done, stalls, busy, rdata, err, ok);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL load_done: got %b expected 1", done); end
    checks++; if (busy != 1) begin failures++; $display("FAIL load_drd_cycles: got %0d expected 1", busy); end
    checks++; if (stalls != 1) begin failures++; $display("FAIL load_stall_cycles: got %0d expected 1", stalls); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_rdata: got %h expected deadbeef", rdata); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL load_err: got %b expected 0", err); end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL load_bus: got %b expected 1", ok); end
    idle_cycles(1);
  endtask

  task automatic test_core_store_waits();
    logic done, err, ok; int stalls, busy; logic [31:0] rdata;
    core_access(1'b1, 32'h0000_0100, 32'h1234_5678, 4, 32'hFFFF_FFFF, done, stalls, busy, rdata, err, ok);
    checks++; if (busy != 4) begin failures++; $display("FAIL store_dwr_cycles: got %0d expected 4", busy); end
    checks++; if (stalls != 4) begin failures++; $display("FAIL store_stall_cycles: got %0d expected 4", stalls); end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL store_bus: got %b expected 1", ok); end
    checks++; if (rdata !== 32'h0 || err !== 1'b0) begin
      failures++; $display("FAIL store_result: got rdata=%h err=%b expected 0/0", rdata, err);
    end
    idle_cycles(1);
  endtask

  task automatic test_starvation();
    logic [31:0] grants[$];
    logic [31:0] exp_addr;
    int gnt_count = 0;
    core_rd_i = 1'b1; core_wr_i = 1'b0; core_addr_i = 32'h1000; core_size_i = 2'b10;
    aux_req_i = 1'b1; aux_we_i = 1'b0; aux_addr_i = 32'h2000; aux_size_i = 2'b10;
    dready_i = 1'b1; drdata_i = 32'h5555_0000;
    for (int c = 0; c < 60 && grants.size() < 10; c++) begin
      @(negedge clk_i);
      if (aux_gnt_o) gnt_count++;
      if (drd_o) grants.push_back(daddr_o);
      @(posedge clk_i); #1;
    end
    core_rd_i = 1'b0; aux_req_i = 1'b0;
    idle_cycles(3);
    dready_i = 1'b0;
    checks++;
    if (grants.size() != 10) begin
      failures++; $display("FAIL starve_grant_count: got %0d expected 10", grants.size());
    end
    for (int i = 0; i < grants.size(); i++) begin
      exp_addr = (i % 5 == 4) ? 32'h2000 : 32'h1000;
      checks++;
      if (grants[i] !== exp_addr) begin
        failures++; $display("FAIL starve_order[%0d]: got %h expected %h", i, grants[i], exp_addr);
      end
    end
    checks++;
    if (gnt_count != 2) begin failures++; $display("FAIL starve_aux_gnt: got %0d expected 2", gnt_count); end
  endtask

  task automatic test_core_timeout();
    logic done, err, ok; int stalls, busy; logic [31:0] rdata;
    core_access(1'b0, 32'h0000_0200, 32'h0, 0, 32'hAAAA_5555, done, stalls, busy, rdata, err, ok);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL tmo_done: got %b expected 1", done); end
    checks++; if (busy != 16) begin failures++; $display("FAIL tmo_busy_cycles: got %0d expected 16", busy); end
    checks++; if (stalls != 16) begin failures++; $display("FAIL tmo_stall_cycles: got %0d expected 16", stalls); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL tmo_err: got %b expected 1", err); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL tmo_rdata: got %h expected 0", rdata); end
    idle_cycles(1);
  endtask

  task automatic test_ready_at_last();
    logic done, err, ok; int stalls, busy; logic [31:0] rdata;
    core_access(1'b0, 32'h0000_0204, 32'h0, 16, 32'hCAFE_F00D, done, stalls, busy, rdata, err, ok);
    checks++; if (busy != 16) begin failures++; $display("FAIL last_busy_cycles: got %0d expected 16", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL last_err: got %b expected 0", err); end
    checks++; if (rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL last_rdata: got %h expected cafef00d", rdata); end
    idle_cycles(1);
  endtask

  task automatic test_aux_read();
    logic done, err; int g, a, r, busy; logic [31:0] rdata;
    aux_access(1'b0, 32'h0000_0300, 32'h0, 1, 32'h0BAD_F00D, done, g, a, r, busy, rdata, err);
    checks++;
    if (g != 0 || a != 1 || r != 2) begin
      failures++; $display("FAIL aux_latency: got gnt=%0d acc=%0d rvalid=%0d expected 0/1/2", g, a, r);
    end
    checks++; if (rdata !== 32'h0BAD_F00D) begin failures++; $display("FAIL aux_rdata: got %h expected 0badf00d", rdata); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL aux_err: got %b expected 0", err); end
    drdata_i = 32'h1111_2222;
    idle_cycles(3);
    @(negedge clk_i);
    checks++;
    if (aux_rdata_o !== 32'h0BAD_F00D || aux_rvalid_o !== 1'b0) begin
      failures++; $display("FAIL aux_rdata_hold: got %h rvalid=%b expected 0badf00d rvalid=0", aux_rdata_o, aux_rvalid_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_aux_timeout();
    logic done, err; int g, a, r, busy; logic [31:0] rdata;
    aux_access(1'b0, 32'h0000_0304, 32'h0, 0, 32'h7777_8888, done, g, a, r, busy, rdata, err);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL aux_tmo_rvalid: got %b expected 1", done); end
    checks++; if (busy != 16 || r != 17) begin
      failures++; $display("FAIL aux_tmo_timing: got busy=%0d rvalid=%0d expected 16/17", busy, r);
    end
    checks++; if (err !== 1'b1 || rdata !== 32'h0) begin
      failures++; $display("FAIL aux_tmo_result: got err=%b rdata=%h expected 1/0", err, rdata);
    end
    idle_cycles(1);
  endtask

  task automatic test_reset_mid_aux();
    logic done, err, ok, seen, granted; int stalls, busy; logic [31:0] rdata;
    granted = 1'b0; seen = 1'b0;
    aux_req_i = 1'b1; aux_we_i = 1'b0; aux_addr_i = 32'h0000_0400; aux_size_i = 2'b10;
    dready_i = 1'b0;
    for (int c = 0; c < 10 && !granted; c++) begin
      @(negedge clk_i);
      if (aux_gnt_o) granted = 1'b1;
      @(posedge clk_i); #1;
    end
    aux_req_i = 1'b0;
    checks++;
    if (!granted || drd_o !== 1'b1) begin
      failures++; $display("FAIL rst_aux_busy: got gnt=%b drd=%b expected 1/1", granted, drd_o);
    end
    #2 reset_ni = 1'b0;
    #1;
    checks++;
    if (drd_o !== 1'b0 || state_o !== 2'd0 || daddr_o !== 32'h0) begin
      failures++; $display("FAIL rst_async_drop: got drd=%b state=%0d addr=%h expected 0/0/0", drd_o, state_o, daddr_o);
    end
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (aux_rvalid_o || aux_err_o) seen = 1'b1;
      @(posedge clk_i); #1;
    end
    checks++;
    if (seen !== 1'b0 || state_o !== 2'd0) begin
      failures++; $display("FAIL rst_no_rvalid: got seen=%b state=%0d expected 0/0", seen, state_o);
    end
    core_access(1'b0, 32'h0000_0500, 32'h0, 1, 32'h1357_9BDF, done, stalls, busy, rdata, err, ok);
    checks++;
    if (done !== 1'b1 || stalls != 1 || rdata !== 32'h1357_9BDF || err !== 1'b0 || ok !== 1'b1) begin
      failures++; $display("FAIL rst_then_load: got done=%b stalls=%0d rdata=%h err=%b bus=%b expected 1/1/13579bdf/0/1",
                           done, stalls, rdata, err, ok);
    end
  endtask

  initial begin
    test_reset();
    test_core_load();
    test_core_store_waits();
    test_starvation();
    test_core_timeout();
    test_ready_at_last();
    test_aux_read();
    test_aux_timeout();
    test_reset_mid_aux();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
